instr_encoder: RTL and testbench
================================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameter DEPTH, default 4, output FIFO depth in entries; legal values are powers of two from 2 to 16.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 flush  input  1  synchronous clear of all buffered instructions.
REQ-005 in_valid  input  1  descriptor valid.
REQ-006 in_ready  output  1  encoder can accept a descriptor.
REQ-007 in_fmt  input  2  format: 00 R-ALU, 01 I-ALU, 10 JALR, 11 JAL.
REQ-008 in_aluop  input  4  0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND; 10-15 undefined.
REQ-009 in_rd / in_rs1 / in_rs2  input  5 each  register indices.
REQ-010 in_imm  input  21  signed immediate; bits [11:0] are used by I and JALR, bits [20:1] by JAL.
REQ-011 out_valid  output  1  FIFO head holds an encoded word.
REQ-012 out_ready  input  1  consumer takes the head word.
REQ-013 out_instr  output  32  encoded RV32I word at the FIFO head.
REQ-014 level  output  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-015 err  output  1  one-cycle pulse flagging an illegal descriptor (see Configuration).

Function
REQ-016 A descriptor is accepted when in_valid && in_ready; the encoder does not register descriptor fields before acceptance.
REQ-017 in_ready = (level < DEPTH) && !flush; a pop in the same cycle does not raise in_ready when the FIFO is full (no pass-through).
REQ-018 R-ALU: opcode 0110011; rd [11:7], rs1 [19:15], rs2 [24:20]; funct3 per the map below; funct7 0100000 for SUB and SRA, 0000000 otherwise.
REQ-019 funct3 map: ADD/SUB 000, SLL 001, SLT 010, SLTU 011, XOR 100, SRL/SRA 101, OR 110, AND 111.
REQ-020 I-ALU: opcode 0010011; [31:20] = imm[11:0]. For SLL/SRL/SRA, [31:25] = funct7 and [24:20] = imm[4:0].
REQ-021 JALR: opcode 1100111, funct3 000, [31:20] = imm[11:0]; in_aluop and in_rs2 are ignored.
REQ-022 JAL: opcode 1101111; [31] = imm[20], [30:21] = imm[10:1], [20] = imm[11], [19:12] = imm[19:12]; rs1, rs2 and aluop are ignored.
REQ-023 An accepted word is written to the FIFO tail; if the FIFO was empty, out_valid rises on the next cycle (1-cycle latency).
REQ-024 Pop occurs when out_valid && out_ready. out_instr always shows the head entry and is held stable while out_valid && !out_ready.
REQ-025 Simultaneous push and pop when 0 < level < DEPTH leaves level unchanged. Read and write pointers wrap modulo DEPTH.
REQ-026 flush empties the FIFO (level = 0, out_valid = 0) on the next edge. flush overrides any push or pop in the same cycle.
REQ-027 The FIFO holds words in acceptance order; it never drops or duplicates a word.

Reset
REQ-028 While rst_n = 0: level = 0, out_valid = 0, err = 0, pointers = 0 and out_instr = 0; in_ready = 0 during reset.
REQ-029 Reset asserted mid-operation discards all buffered words immediately. in_ready rises on the first clock edge after rst_n deasserts.

Configuration
REQ-030 Macro INSTR_ENCODER_CHECK_EN enables illegal-descriptor checking.
REQ-031 When the macro is defined, a descriptor is illegal if any of these holds: R-ALU or I-ALU with aluop > 9; I-ALU with SUB; I-ALU shift with imm[11:5] != 0; JAL with imm[0] = 1.
REQ-032 When the macro is defined, an illegal descriptor is still accepted (handshake completes) but is not written to the FIFO; err pulses high for exactly one cycle on the cycle after acceptance.
REQ-033 When the macro is not defined, err is tied 0, and all descriptors are encoded: aluop > 9 encodes as ADD, I-ALU SUB encodes as ADDI, and shift immediates take only imm[4:0].

Verification
REQ-034 Reset, then push R SUB rd=3 rs1=1 rs2=2 -> out_instr = 0x402081B3 with out_valid high one cycle after acceptance.
REQ-035 Push I SRA rd=5 rs1=6 imm=4, then JAL rd=1 imm=0x000008 -> 0x40435293, then 0x008000EF, in order.
REQ-036 With out_ready held at 0, push DEPTH+1 descriptors -> in_ready = 0 once level = DEPTH; the extra descriptor is held off; draining returns all words in order.
REQ-037 At level = 2, assert push, pop and flush in the same cycle -> level = 0 and out_valid = 0 on the next cycle; no word is written.
REQ-038 With CHECK_EN defined, push I SUB -> err pulses for 1 cycle and level is unchanged. Without CHECK_EN, the same push yields ADDI encoding and err = 0.
REQ-039 Drop rst_n while level = 3 -> out_valid = 0 and level = 0 asynchronously; the next push after release encodes correctly.

Source files
------------

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - RV32I instruction encoder with output FIFO
//
// Purpose: turns an instruction descriptor (format, ALU op, registers,
// immediate) into a 32-bit RV32I word and queues it in a DEPTH-entry FIFO.
//
// Optional feature: define INSTR_ENCODER_CHECK_EN to reject illegal
// descriptors (accepted on the handshake, not queued, err pulses).
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   flush      synchronous clear of the FIFO (wins over push and pop)
//   in_valid   descriptor valid
//   in_ready   descriptor can be accepted
//   in_fmt     00 R-ALU, 01 I-ALU, 10 JALR, 11 JAL
//   in_aluop   0 ADD .. 9 AND
//   in_rd      destination register
//   in_rs1     source register 1
//   in_rs2     source register 2
//   in_imm     21-bit signed immediate
//   out_valid  FIFO head holds a word
//   out_ready  consumer takes the head word
//   out_instr  encoded word at the FIFO head (0 when empty)
//   level      FIFO occupancy
//   err        one-cycle pulse after an illegal descriptor is accepted

module instr_encoder #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [1:0]               in_fmt,
  input  logic [3:0]               in_aluop,
  input  logic [4:0]               in_rd,
  input  logic [4:0]               in_rs1,
  input  logic [4:0]               in_rs2,
  input  logic [20:0]              in_imm,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_instr,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);

  localparam logic [1:0] FMT_R    = 2'b00;
  localparam logic [1:0] FMT_I    = 2'b01;
  localparam logic [1:0] FMT_JALR = 2'b10;
  localparam logic [1:0] FMT_JAL  = 2'b11;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_SLL  = 4'd2;
  localparam logic [3:0] OP_SLT  = 4'd3;
  localparam logic [3:0] OP_SLTU = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_OR   = 4'd8;
  localparam logic [3:0] OP_AND  = 4'd9;

  localparam logic [6:0] OPC_R    = 7'b0110011;
  localparam logic [6:0] OPC_I    = 7'b0010011;
  localparam logic [6:0] OPC_JALR = 7'b1100111;
  localparam logic [6:0] OPC_JAL  = 7'b1101111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // ---------------------------------------------------------------------
  // Encoder (purely combinational on the live descriptor fields)
  // ---------------------------------------------------------------------
  logic [3:0]  op_eff;
  logic [2:0]  funct3;
  logic        is_shift;
  logic [6:0]  funct7_r;
  logic [6:0]  funct7_i;
  logic [31:0] enc_word;
  logic        illegal;

  always_comb begin
    // Undefined ALU codes fold to ADD so every descriptor has an encoding.
    op_eff = (in_aluop > OP_AND) ? OP_ADD : in_aluop;

    funct3 = 3'b000;
    case (op_eff)
      OP_ADD, OP_SUB: funct3 = 3'b000;
      OP_SLL:         funct3 = 3'b001;
      OP_SLT:         funct3 = 3'b010;
      OP_SLTU:        funct3 = 3'b011;
      OP_XOR:         funct3 = 3'b100;
      OP_SRL, OP_SRA: funct3 = 3'b101;
      OP_OR:          funct3 = 3'b110;
      OP_AND:         funct3 = 3'b111;
      default:        funct3 = 3'b000;
    endcase

    is_shift = (op_eff == OP_SLL) || (op_eff == OP_SRL) || (op_eff == OP_SRA);
    funct7_r = ((op_eff == OP_SUB) || (op_eff == OP_SRA)) ? F7_ALT : F7_BASE;
    // I-type has no SUB form; SUB lands on funct3 000 and becomes ADDI.
    funct7_i = (op_eff == OP_SRA) ? F7_ALT : F7_BASE;
  end

  always_comb begin
    enc_word = '0;
    case (in_fmt)
      FMT_R: begin
        enc_word = {funct7_r, in_rs2, in_rs1, funct3, in_rd, OPC_R};
      end
      FMT_I: begin
        if (is_shift) begin
          // Shift amount is imm[4:0]; the upper immediate bits are replaced
          // by funct7.
          enc_word = {funct7_i, in_imm[4:0], in_rs1, funct3, in_rd, OPC_I};
        end else begin
          enc_word = {in_imm[11:0], in_rs1, funct3, in_rd, OPC_I};
        end
      end
      FMT_JALR: begin
        enc_word = {in_imm[11:0], in_rs1, 3'b000, in_rd, OPC_JALR};
      end
      default: begin
        // JAL scrambles imm[20:1] into the J-type layout; imm[0] is implied 0.
        enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                    in_rd, OPC_JAL};
      end
    endcase
  end

`ifdef INSTR_ENCODER_CHECK_EN
  always_comb begin
    illegal = 1'b0;
    case (in_fmt)
      FMT_R:   illegal = (in_aluop > OP_AND);
      FMT_I:   illegal = (in_aluop > OP_AND) || (in_aluop == OP_SUB) ||
                         (is_shift && (in_imm[11:5] != 7'd0));
      FMT_JAL: illegal = in_imm[0];
      default: illegal = 1'b0;
    endcase
  end
`else
  assign illegal = 1'b0;
`endif

  // ---------------------------------------------------------------------
  // Output FIFO
  // ---------------------------------------------------------------------
  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          ready_en;
  logic          accept;
  logic          push;
  logic          pop;

  // ready_en holds in_ready low through reset and releases it on the first
  // edge after rst_n deasserts. No pass-through: a full FIFO stays not-ready
  // even when a pop is happening in the same cycle.
  assign in_ready  = ready_en && (count != FULL_LEVEL) && !flush;
  assign accept    = in_valid && in_ready;
  assign push      = accept && !illegal;
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  assign level     = count;
  assign out_instr = out_valid ? mem[rd_ptr] : 32'd0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      ready_en <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        // Pointers are AW bits wide and DEPTH is a power of two, so the
        // increment wraps modulo DEPTH on its own.
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  // Storage needs no reset: out_instr is gated by out_valid.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr] <= enc_word;
    end
  end

`ifdef INSTR_ENCODER_CHECK_EN
  logic err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= accept && illegal;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - scoreboard bench for instr_encoder

module tb_instr_encoder;

  localparam int DEPTH = 4;

  logic                   clk;
  logic                   rst_n;
  logic                   flush;
  logic                   in_valid;
  logic                   in_ready;
  logic [1:0]             in_fmt;
  logic [3:0]             in_aluop;
  logic [4:0]             in_rd;
  logic [4:0]             in_rs1;
  logic [4:0]             in_rs2;
  logic [20:0]            in_imm;
  logic                   out_valid;
  logic                   out_ready;
  logic [31:0]            out_instr;
  logic [$clog2(DEPTH):0] level;
  logic                   err;

  instr_encoder #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_fmt    (in_fmt),
    .in_aluop  (in_aluop),
    .in_rd     (in_rd),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_imm    (in_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .level     (level),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  fmt;
    logic [3:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [20:0] imm;
    logic [31:0] word;
    bit          bad_chk;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] sb[$];
  int          total = 0;
  int          bad = 0;
  bit          rdy_en = 1'b0;
  bit          exp_err = 1'b0;
  bit          last_fire = 1'b0;
  bit          cur_legal = 1'b1;
  logic [31:0] cur_word = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic add(input logic [1:0] fmt, input logic [3:0] op, input logic [4:0] rd,
                     input logic [4:0] rs1, input logic [4:0] rs2, input logic [20:0] imm,
                     input logic [31:0] word, input bit bad_chk);
    vec_t v;
    v.fmt = fmt; v.op = op; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
    v.imm = imm; v.word = word; v.bad_chk = bad_chk;
    vecs.push_back(v);
  endtask

  task automatic drive(input int idx);
    in_fmt   = vecs[idx].fmt;
    in_aluop = vecs[idx].op;
    in_rd    = vecs[idx].rd;
    in_rs1   = vecs[idx].rs1;
    in_rs2   = vecs[idx].rs2;
    in_imm   = vecs[idx].imm;
    cur_word = vecs[idx].word;
`ifdef INSTR_ENCODER_CHECK_EN
    cur_legal = !vecs[idx].bad_chk;
`else
    cur_legal = 1'b1;
`endif
    in_valid = 1'b1;
  endtask

  // Called just after a negedge with inputs already driven; checks outputs,
  // advances the model across the next posedge, and returns at the next negedge.
  task automatic cycle();
    bit exp_ready;
    bit fire_in;
    bit fire_out;
    #1;
    exp_ready = rdy_en && (sb.size() < DEPTH) && !flush;
    chk("in_ready", 32'(in_ready), 32'(exp_ready));
    chk("out_valid", 32'(out_valid), 32'(sb.size() != 0));
    chk("level", 32'(level), sb.size());
    chk("err", 32'(err), 32'(exp_err));
    fire_out = (sb.size() != 0) && out_ready;
    if (sb.size() != 0) chk(fire_out ? "pop_word" : "head_word", out_instr, sb[0]);
    fire_in   = in_valid && exp_ready;
    last_fire = fire_in;
    exp_err   = fire_in && !cur_legal;
    if (flush) begin
      sb.delete();
    end else begin
      if (fire_out) void'(sb.pop_front());
      if (fire_in && cur_legal) sb.push_back(cur_word);
    end
    rdy_en = 1'b1;
    @(negedge clk);
  endtask

  task automatic push_vec(input int idx, input bit rnd);
    drive(idx);
    for (int n = 0; n < 40; n++) begin
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      cycle();
      if (last_fire) break;
    end
    chk("push_accept", 32'(last_fire), 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int n = 0; n < 40; n++) begin
      if (sb.size() == 0) break;
      cycle();
    end
    chk("drain_left", sb.size(), 32'd0);
    cycle();
  endtask

  initial begin
    // fmt, op, rd, rs1, rs2, imm, expected word (default build), illegal-when-checked
    add(2'd0, 4'd1,  5'd3,  5'd1,  5'd2,  21'd0,        32'h402081B3, 1'b0); // 0 sub x3,x1,x2
    add(2'd1, 4'd7,  5'd5,  5'd6,  5'd0,  21'd4,        32'h40435293, 1'b0); // 1 srai x5,x6,4
    add(2'd3, 4'd0,  5'd1,  5'd0,  5'd0,  21'h000008,   32'h008000EF, 1'b0); // 2 jal x1,8
    add(2'd0, 4'd0,  5'd1,  5'd2,  5'd3,  21'd0,        32'h003100B3, 1'b0); // 3 add
    add(2'd0, 4'd9,  5'd10, 5'd11, 5'd12, 21'd0,        32'h00C5F533, 1'b0); // 4 and
    add(2'd1, 4'd0,  5'd1,  5'd0,  5'd0,  21'h1FFFFF,   32'hFFF00093, 1'b0); // 5 addi -1
    add(2'd2, 4'd5,  5'd0,  5'd1,  5'd31, 21'd0,        32'h00008067, 1'b0); // 6 jalr x0,0(x1)
    add(2'd1, 4'd2,  5'd2,  5'd2,  5'd0,  21'd3,        32'h00311113, 1'b0); // 7 slli
    add(2'd0, 4'd7,  5'd7,  5'd8,  5'd9,  21'd0,        32'h409453B3, 1'b0); // 8 sra
    add(2'd1, 4'd5,  5'd4,  5'd5,  5'd0,  21'h0007FF,   32'h7FF2C213, 1'b0); // 9 xori 2047
    add(2'd3, 4'd3,  5'd0,  5'd7,  5'd7,  21'h1FFFFE,   32'hFFFFF06F, 1'b0); // 10 jal x0,-2
    add(2'd1, 4'd6,  5'd1,  5'd1,  5'd0,  21'd31,       32'h01F0D093, 1'b0); // 11 srli 31
    add(2'd0, 4'd4,  5'd31, 5'd30, 5'd29, 21'd0,        32'h01DF3FB3, 1'b0); // 12 sltu
    add(2'd1, 4'd1,  5'd1,  5'd2,  5'd0,  21'd5,        32'h00510093, 1'b1); // 13 I SUB
    add(2'd0, 4'd12, 5'd1,  5'd2,  5'd3,  21'd0,        32'h003100B3, 1'b1); // 14 aluop 12
    add(2'd1, 4'd2,  5'd2,  5'd2,  5'd0,  21'h000023,   32'h00311113, 1'b1); // 15 slli big imm
    add(2'd3, 4'd0,  5'd1,  5'd0,  5'd0,  21'h000009,   32'h008000EF, 1'b1); // 16 jal odd imm

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_fmt = '0; in_aluop = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cycle();

    // Single push, then two words in order.
    out_ready = 1'b1;
    push_vec(0, 1'b0);
    drain();
    out_ready = 1'b0;
    push_vec(1, 1'b0);
    push_vec(2, 1'b0);
    drain();

    // Mixed encodings under random backpressure.
    for (int i = 3; i <= 12; i++) push_vec(i, 1'b1);
    drain();

    // Fill to DEPTH with the consumer stalled; the extra descriptor waits.
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) push_vec(3 + i, 1'b0);
    drive(3 + DEPTH);
    repeat (3) cycle();
    chk("held_level", 32'(level), 32'(DEPTH));
    out_ready = 1'b1;
    for (int n = 0; n < 20; n++) begin
      cycle();
      if (last_fire) break;
    end
    in_valid = 1'b0;
    drain();

    // Flush with push and pop at level 2.
    out_ready = 1'b0;
    push_vec(4, 1'b0);
    push_vec(5, 1'b0);
    drive(6);
    out_ready = 1'b1;
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    cycle();
    chk("flush_level", 32'(level), 32'd0);
    cycle();

    // Descriptors whose handling depends on checking being built in.
    for (int i = 13; i <= 16; i++) begin
      out_ready = 1'b0;
      push_vec(i, 1'b0);
      cycle();
      drain();
    end

    // Asynchronous reset with three words buffered.
    out_ready = 1'b0;
    for (int i = 7; i <= 9; i++) push_vec(i, 1'b0);
    chk("pre_rst_level", 32'(level), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_level", 32'(level), 32'd0);
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd0);
    chk("arst_out_instr", out_instr, 32'd0);
    sb.delete();
    rdy_en = 1'b0;
    exp_err = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cycle();
    push_vec(0, 1'b0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
